// File: rtl/score_time_ctrl.sv
// score_time_ctrl: Pacman HUD game-status controller.
// Keeps the 3-digit BCD score and the 3-digit BCD countdown timer. Score
// events are queued in small per-type counters and credited one per cycle
// through a fixed-priority arbiter. A prescaler derives the 1 s timer tick.
module score_time_ctrl #(
  parameter int unsigned CLK_FREQ   = 31500000,
  parameter logic [11:0] START_TIME = 12'h120,
  parameter int unsigned PELLET_PTS = 1,
  parameter int unsigned POWER_PTS  = 5,
  parameter int unsigned GHOST_PTS  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_start,
  input  logic       pause,
  input  logic       pellet_eaten,
  input  logic       power_eaten,
  input  logic       ghost_eaten,
  output logic [3:0] digit_score_ones,
  output logic [3:0] digit_score_tens,
  output logic [3:0] digit_score_hundreds,
  output logic [3:0] digit_time_ones,
  output logic [3:0] digit_time_tens,
  output logic [3:0] digit_time_hundreds,
  output logic       running,
  output logic       time_up,
  output logic       score_sat
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_TIMEOUT} state_t;

  localparam int unsigned    PW       = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]  PRESC_TC = PW'(CLK_FREQ - 1);

  // Point values split into BCD tens/ones once, at elaboration.
  localparam logic [3:0] PEL_T = 4'(PELLET_PTS / 10);
  localparam logic [3:0] PEL_O = 4'(PELLET_PTS % 10);
  localparam logic [3:0] POW_T = 4'(POWER_PTS / 10);
  localparam logic [3:0] POW_O = 4'(POWER_PTS % 10);
  localparam logic [3:0] GHO_T = 4'(GHOST_PTS / 10);
  localparam logic [3:0] GHO_O = 4'(GHOST_PTS % 10);

  // Index of each event type in the pending/select vectors.
  localparam int EV_PEL = 0;
  localparam int EV_POW = 1;
  localparam int EV_GHO = 2;

  state_t          state_q, state_d;
  logic [11:0]     score_q, score_d;
  logic [11:0]     timer_q, timer_d;
  logic [2:0][1:0] pend_q, pend_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, running_d;
  logic            time_up_q, time_up_d;
  logic            sat_q, sat_d;

  logic [2:0]      sel;
  logic [2:0]      ev;
  logic [3:0]      add_t, add_o;
  logic [4:0]      sum_o, sum_t, sum_h;
  logic            c0, c1;
  logic [11:0]     score_add;
  logic [11:0]     timer_dec;
  logic            sec_tick;

  // Fixed-priority pick of one pending event type: ghost > power > pellet.
  always_comb begin
    sel   = '0;
    add_t = '0;
    add_o = '0;
    if (pend_q[EV_GHO] != 2'd0) begin
      sel[EV_GHO] = 1'b1; add_t = GHO_T; add_o = GHO_O;
    end else if (pend_q[EV_POW] != 2'd0) begin
      sel[EV_POW] = 1'b1; add_t = POW_T; add_o = POW_O;
    end else if (pend_q[EV_PEL] != 2'd0) begin
      sel[EV_PEL] = 1'b1; add_t = PEL_T; add_o = PEL_O;
    end
  end

  // BCD add of the selected 2-digit addend, clamped to 999 on overflow.
  always_comb begin
    c0    = 1'b0;
    c1    = 1'b0;
    sum_o = {1'b0, score_q[3:0]} + {1'b0, add_o};
    if (sum_o > 5'd9) begin
      sum_o = sum_o - 5'd10;
      c0    = 1'b1;
    end
    sum_t = {1'b0, score_q[7:4]} + {1'b0, add_t} + {4'd0, c0};
    if (sum_t > 5'd9) begin
      sum_t = sum_t - 5'd10;
      c1    = 1'b1;
    end
    sum_h = {1'b0, score_q[11:8]} + {4'd0, c1};
    if (sum_h > 5'd9) score_add = 12'h999;
    else              score_add = {sum_h[3:0], sum_t[3:0], sum_o[3:0]};
  end

  // BCD decrement with borrow; only applied while the timer is nonzero.
  always_comb begin
    timer_dec = timer_q;
    if (timer_q[3:0] != 4'd0) begin
      timer_dec[3:0] = timer_q[3:0] - 4'd1;
    end else begin
      timer_dec[3:0] = 4'd9;
      if (timer_q[7:4] != 4'd0) begin
        timer_dec[7:4] = timer_q[7:4] - 4'd1;
      end else begin
        timer_dec[7:4]  = 4'd9;
        timer_dec[11:8] = timer_q[11:8] - 4'd1;
      end
    end
  end

  // Next-state: prescaler, timer, event queues, score and game phase.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    timer_d   = timer_q;
    pend_d    = pend_q;
    presc_d   = presc_q;
    time_up_d = 1'b0;
    sec_tick  = 1'b0;

    // The timer is frozen whenever pause is high, even on the RUN cycle
    // that is about to enter PAUSED.
    if (state_q == S_RUN && !pause) begin
      if (presc_q == PRESC_TC) begin
        presc_d  = '0;
        sec_tick = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (sec_tick && timer_q != 12'h000) timer_d = timer_dec;

    // Credit the arbitrated event in any state so earned points drain.
    if (|sel) score_d = score_add;

    // Capture only in RUN; capture+service on one counter cancels out.
    ev = {ghost_eaten, power_eaten, pellet_eaten} & {3{state_q == S_RUN}};
    for (int i = 0; i < 3; i++) begin
      if (ev[i] && !sel[i] && pend_q[i] != 2'd3) pend_d[i] = pend_q[i] + 2'd1;
      else if (!ev[i] && sel[i])                 pend_d[i] = pend_q[i] - 2'd1;
    end

    case (state_q)
      S_RUN: begin
        if (sec_tick && timer_d == 12'h000) begin
          state_d   = S_TIMEOUT;
          time_up_d = 1'b1;
        end else if (pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: if (!pause) state_d = S_RUN;
      default: ;
    endcase

    // game_start overrides everything, including same-cycle events.
    if (game_start) begin
      score_d   = 12'h000;
      timer_d   = START_TIME;
      presc_d   = '0;
      pend_d    = '0;
      state_d   = (START_TIME == 12'h000) ? S_TIMEOUT : S_RUN;
      time_up_d = (START_TIME == 12'h000);
    end

    running_d = (state_d == S_RUN);
    sat_d     = (score_d == 12'h999);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      score_q   <= 12'h000;
      timer_q   <= START_TIME;
      pend_q    <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      time_up_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      time_up_q <= time_up_d;
      sat_q     <= sat_d;
    end
  end

  assign digit_score_ones     = score_q[3:0];
  assign digit_score_tens     = score_q[7:4];
  assign digit_score_hundreds = score_q[11:8];
  assign digit_time_ones      = timer_q[3:0];
  assign digit_time_tens      = timer_q[7:4];
  assign digit_time_hundreds  = timer_q[11:8];
  assign running              = running_q;
  assign time_up              = time_up_q;
  assign score_sat            = sat_q;

endmodule

// File: doc/score_time_ctrl.md
Name: score_time_ctrl

Overview:
- Game-status controller for the Pacman HUD.
- Maintains the 3-digit BCD score and the 3-digit BCD countdown timer.
- Drives the digit inputs of the HUD number renderer: score ones/tens/hundreds and time ones/tens/hundreds.
- Serialises simultaneous score events through a priority arbiter, derives a 1 s tick from the pixel clock, and runs the game-phase state machine (idle/run/pause/timeout).

Parameters:
- CLK_FREQ, 31500000, clk cycles per game second (1 s tick prescaler terminal count +1).
- START_TIME, 12'h120, timer load value, 3 BCD digits.
- PELLET_PTS, 1, points per pellet (0..99, binary).
- POWER_PTS, 5, points per power pellet (0..99).
- GHOST_PTS, 20, points per ghost eaten (0..99).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- game_start  in  1  one-cycle pulse; clears score, loads timer, enters RUN.
- pause  in  1  level; freezes timer while high.
- pellet_eaten  in  1  one-cycle event pulse.
- power_eaten  in  1  one-cycle event pulse.
- ghost_eaten  in  1  one-cycle event pulse.
- digit_score_ones/tens/hundreds  out  4 each  score BCD digits.
- digit_time_ones/tens/hundreds  out  4 each  timer BCD digits.
- running  out  1  high in RUN only.
- time_up  out  1  one-cycle pulse on entering TIMEOUT.
- score_sat  out  1  high while score == 999.

Behaviour:
- Reset (synchronous): state=IDLE; all score digits 0; timer digits = START_TIME; pending counters 0; prescaler 0; running=0; time_up=0; score_sat=0.
- States:
  - IDLE: wait.
  - RUN: timer counting, events accepted.
  - PAUSED: timer frozen, events ignored.
  - TIMEOUT: terminal state.
- Transitions:
  - game_start in any state -> RUN. Score=000, timer=START_TIME, prescaler=0, pending cleared.
  - If START_TIME==000, game_start -> TIMEOUT directly and time_up pulses.
  - RUN & pause -> PAUSED. PAUSED & !pause -> RUN. pause is ignored in IDLE and TIMEOUT.
  - RUN & timer decrements to 000 -> TIMEOUT; time_up=1 for exactly that cycle.
- game_start has priority over every other input in the same cycle; events arriving in that cycle are dropped.
- Prescaler:
  - Counts 0..CLK_FREQ-1 in RUN only; holds its value in PAUSED.
  - At terminal count it wraps to 0 and the timer decrements by 1 (BCD, borrow ones->tens->hundreds).
  - Timer never goes below 000.
- Event capture:
  - Only in RUN. Each event type has a 2-bit pending counter.
  - A pulse sampled at edge E increments its counter, saturating at 3; excess events are lost.
  - Counters are cleared only by reset or game_start.
- Arbiter:
  - Each cycle with any pending counter nonzero, selects one type. Priority: ghost > power > pellet.
  - Decrements the selected counter and adds that type's points to the score at the same edge.
  - Single isolated event latency: pulse at edge E, digits updated at edge E+1.
  - Three simultaneous events: ghost added at E+1, power at E+2, pellet at E+3.
  - A same-cycle capture and service on one counter leaves it unchanged.
  - Draining continues in PAUSED and TIMEOUT, so already-earned points are credited.
- Score arithmetic:
  - BCD add of a 2-digit addend (points converted to tens/ones at elaboration).
  - Per-digit carry: a digit sum >9 subtracts 10 and carries 1.
  - If the result would exceed 999, score = 999 (saturate); score_sat=1.
  - Score never wraps.
- All digit outputs are registered, and each is always in the range 0..9.

Test Plan:
- Reset, then game_start with CLK_FREQ=10, START_TIME=12'h003 -> timer 3,2,1,0 at 10-cycle intervals; time_up single pulse at the 30th cycle after start; running falls the same edge.
- In RUN, pellet_eaten, power_eaten, ghost_eaten pulsed in the same cycle E -> score 020 at E+1, 025 at E+2, 026 at E+3.
- pellet_eaten pulsed 5 times back-to-back while ghost_eaten is also held pending -> score reflects 20 plus at most 3 pellets queued beyond those served; exact sequence is checked against the model; no score digit is ever >9.
- Score preloaded near the limit by 50 ghost events (1000 points) -> digits 9/9/9, score_sat=1, no wrap.
- pause high for 25 cycles in mid-second at prescaler=4 -> timer unchanged and events ignored; after release, the next decrement occurs 6 cycles later.
- game_start asserted in the same cycle as ghost_eaten while in TIMEOUT -> score 000, timer = START_TIME, state RUN, no points added. reset mid-run -> IDLE with all reset values next cycle.
